fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream_if.sv | 29 ++
 rtl/fifo_rd_stream.sv | 84 ++++++++
 tb/tb_fifo_rd_stream.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// Bundle between fifo_rd_stream, the upstream 1-cycle-latency FIFO read port
// and the downstream valid/ready consumer. master = the adapter itself.
interface fifo_rd_stream_if #(
    parameter int WIDTH = 8,
    parameter int SKID  = 4,
    parameter int CW    = 16
);
    localparam int LW = $clog2(SKID) + 1;

    logic             in_fifo_empty;
    logic             out_fifo_rd;
    logic [WIDTH-1:0] in_fifo_rdata;
    logic             out_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             in_flush;
    logic [LW-1:0]    out_level;
    logic [CW-1:0]    out_beats;

    modport master (
        input  in_fifo_empty, in_fifo_rdata, in_ready, in_flush,
        output out_fifo_rd, out_valid, out_data, out_level, out_beats
    );

    modport slave (
        output in_fifo_empty, in_fifo_rdata, in_ready, in_flush,
        input  out_fifo_rd, out_valid, out_data, out_level, out_beats
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Turns a pop-with-1-cycle-latency FIFO read port into a full-throughput
// valid/ready stream using a small skid store that absorbs in-flight reads.
module fifo_rd_stream #(
    parameter int WIDTH = 8,
    parameter int SKID  = 4,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    fifo_rd_stream_if.master bus
);
    localparam int LW = $clog2(SKID) + 1;
    localparam int PW = (SKID > 1) ? $clog2(SKID) : 1;

    logic [LW-1:0]    occ_reg;
    logic [LW-1:0]    occ_next;
    logic             pend_reg;
    logic [PW-1:0]    wptr_reg;
    logic [PW-1:0]    rptr_reg;
    logic [CW-1:0]    beats_reg;
    logic [WIDTH-1:0] skid_mem [SKID];

    logic             fifo_rd;
    logic             capture;
    logic             valid;
    logic             pop;
    logic [LW:0]      fill;

    // Reserve a slot for every word already requested, so a pop can never
    // be issued without room to land it.
    assign fill    = {1'b0, occ_reg} + {{LW{1'b0}}, pend_reg};
    assign fifo_rd = !rst && !bus.in_fifo_empty && !bus.in_flush
                     && (fill < (LW + 1)'(SKID));
    assign capture = pend_reg && !bus.in_flush;
    assign valid   = (occ_reg != '0);
    assign pop     = valid && bus.in_ready;

    always_comb begin
        occ_next = occ_reg + {{(LW - 1){1'b0}}, capture}
                           - {{(LW - 1){1'b0}}, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_reg   <= '0;
            pend_reg  <= 1'b0;
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            beats_reg <= '0;
        end else begin
            pend_reg <= fifo_rd;
            // Beat counter survives flush: a beat accepted in the flush cycle still happened.
            if (pop) begin
                beats_reg <= beats_reg + CW'(1);
            end
            if (bus.in_flush) begin
                occ_reg  <= '0;
                wptr_reg <= '0;
                rptr_reg <= '0;
            end else begin
                occ_reg <= occ_next;
                if (capture) begin
                    wptr_reg <= wptr_reg + PW'(1);
                end
                if (pop) begin
                    rptr_reg <= rptr_reg + PW'(1);
                end
            end
        end
    end

    // Storage carries no reset; occ gates which entries are meaningful.
    always_ff @(posedge clk) begin
        if (capture) begin
            skid_mem[wptr_reg] <= bus.in_fifo_rdata;
        end
    end

    assign bus.out_fifo_rd = fifo_rd;
    assign bus.out_valid   = valid;
    assign bus.out_data    = skid_mem[rptr_reg];
    assign bus.out_level   = occ_reg;
    assign bus.out_beats   = beats_reg;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: upstream FIFO and expected stream are modelled as
// queues of fetched words with fetch timestamps; a second instance checks SKID=2/CW=4.
module tb_fifo_rd_stream;
    localparam int SKID = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_stream_if #(.WIDTH(8), .SKID(4), .CW(16)) a ();
    fifo_rd_stream_if #(.WIDTH(8), .SKID(2), .CW(4))  b ();

    fifo_rd_stream #(.WIDTH(8), .SKID(4), .CW(16)) dut_a (.clk(clk), .rst(rst), .bus(a.master));
    fifo_rd_stream #(.WIDTH(8), .SKID(2), .CW(4))  dut_b (.clk(clk), .rst(rst), .bus(b.master));

    typedef struct { logic [7:0] w; int t; } inflight_t;

    logic [7:0] fq[$];          // words still inside the upstream FIFO
    inflight_t  exp_q[$];       // words fetched from the FIFO, not yet delivered
    int         cyc, beats_model, n_tests, n_fail;
    logic       rd_prev;
    logic [7:0] rd_word;

    logic       s_rd, s_valid, s_empty;
    logic [7:0] s_data;
    logic [2:0] s_level;
    logic [15:0] s_beats;
    logic       m_rd, m_valid, m_acc;
    logic [7:0] m_front;
    int         m_level, m_beats;

    task automatic reset_model();
        fq.delete();
        exp_q.delete();
        rd_prev     = 1'b0;
        beats_model = 0;
    endtask

    // One clock of the environment: drive inputs, sample outputs, predict, advance.
    task automatic tick(input logic rdy, input logic fl);
        a.in_fifo_rdata = rd_prev ? rd_word : 8'($urandom);
        a.in_fifo_empty = (fq.size() == 0);
        a.in_ready      = rdy;
        a.in_flush      = fl;
        #1;
        s_rd = a.out_fifo_rd; s_valid = a.out_valid; s_data = a.out_data;
        s_level = a.out_level; s_beats = a.out_beats; s_empty = a.in_fifo_empty;
        m_level = 0;
        foreach (exp_q[i]) if (exp_q[i].t + 2 <= cyc) m_level++;
        m_valid = (m_level != 0);
        m_front = (exp_q.size() != 0) ? exp_q[0].w : 8'h00;
        m_rd    = !s_empty && !fl && (exp_q.size() < SKID);
        m_acc   = m_valid && rdy;
        m_beats = beats_model;
        if (m_acc) begin
            void'(exp_q.pop_front());
            beats_model++;
            $display("[TB] cyc %0d beat %0d data %h", cyc, beats_model, s_data);
        end
        if (fl) exp_q.delete();
        rd_prev = s_rd;
        if (s_rd && fq.size() != 0) begin
            rd_word = fq.pop_front();
            exp_q.push_back(inflight_t'{w: rd_word, t: cyc});
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        a.in_fifo_empty = 1'b0; a.in_fifo_rdata = 8'h00; a.in_ready = 1'b0; a.in_flush = 1'b0;
        b.in_fifo_empty = 1'b1; b.in_fifo_rdata = 8'h00; b.in_ready = 1'b0; b.in_flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (a.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", a.out_valid); end
        n_tests++; if (a.out_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d exp 0", a.out_level); end
        n_tests++; if (a.out_beats !== 16'd0) begin n_fail++; $display("FAIL reset_beats: got %0d exp 0", a.out_beats); end
        n_tests++; if (a.out_fifo_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b exp 0", a.out_fifo_rd); end
        rst = 1'b0;
        reset_model();
    endtask

    task automatic test_basic();
        bit [5:0]   rd_pat = 6'b000111;
        bit [5:0]   v_pat  = 6'b011100;
        logic [7:0] d_pat [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        fq = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0);
            n_tests++; if (s_rd !== rd_pat[i]) begin n_fail++; $display("FAIL basic_rd c%0d: got %b exp %b", i, s_rd, rd_pat[i]); end
            n_tests++; if (s_valid !== v_pat[i]) begin n_fail++; $display("FAIL basic_valid c%0d: got %b exp %b", i, s_valid, v_pat[i]); end
            if (v_pat[i]) begin
                n_tests++; if (s_data !== d_pat[i]) begin n_fail++; $display("FAIL basic_data c%0d: got %h exp %h", i, s_data, d_pat[i]); end
            end
        end
        n_tests++; if (s_beats !== 16'd3) begin n_fail++; $display("FAIL basic_beats: got %0d exp 3", s_beats); end
    endtask

    task automatic test_stream();
        int first = -1, last = -1, cnt = 0;
        for (int k = 0; k < 16; k++) fq.push_back(8'($urandom));
        for (int i = 0; i < 24; i++) begin
            tick(1'b1, 1'b0);
            n_tests++; if (s_rd && s_empty) begin n_fail++; $display("FAIL stream_rd_empty c%0d: got rd=1 exp 0", i); end
            n_tests++; if (s_rd !== m_rd) begin n_fail++; $display("FAIL stream_rd c%0d: got %b exp %b", i, s_rd, m_rd); end
            n_tests++; if (s_valid !== m_valid) begin n_fail++; $display("FAIL stream_valid c%0d: got %b exp %b", i, s_valid, m_valid); end
            if (m_valid) begin
                n_tests++; if (s_data !== m_front) begin n_fail++; $display("FAIL stream_data c%0d: got %h exp %h", i, s_data, m_front); end
            end
            if (s_valid) begin
                if (first < 0) first = i;
                last = i;
                cnt++;
            end
        end
        n_tests++; if (cnt !== 16) begin n_fail++; $display("FAIL stream_count: got %0d exp 16", cnt); end
        n_tests++; if (first !== 2) begin n_fail++; $display("FAIL stream_first: got %0d exp 2", first); end
        n_tests++; if (last - first !== 15) begin n_fail++; $display("FAIL stream_span: got %0d exp 15", last - first); end
    endtask

    task automatic test_backpressure();
        int k = 0;
        for (int j = 1; j <= 8; j++) fq.push_back(8'(8'h11 * j));
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            n_tests++; if (s_rd !== m_rd) begin n_fail++; $display("FAIL bp_rd c%0d: got %b exp %b", i, s_rd, m_rd); end
            n_tests++; if (s_level > 3'd4) begin n_fail++; $display("FAIL bp_level_max c%0d: got %0d exp <=4", i, s_level); end
            if (s_valid) begin
                n_tests++; if (s_data !== 8'h11) begin n_fail++; $display("FAIL bp_hold c%0d: got %h exp 11", i, s_data); end
            end
        end
        n_tests++; if (s_level !== 3'd4) begin n_fail++; $display("FAIL bp_level: got %0d exp 4", s_level); end
        n_tests++; if (s_rd !== 1'b0) begin n_fail++; $display("FAIL bp_rd_full: got %b exp 0", s_rd); end
        for (int i = 0; i < 20 && k < 8; i++) begin
            tick(1'b1, 1'b0);
            if (s_valid) begin
                k++;
                n_tests++; if (s_data !== 8'(8'h11 * k)) begin n_fail++; $display("FAIL bp_drain %0d: got %h exp %h", k, s_data, 8'(8'h11 * k)); end
            end
        end
        n_tests++; if (k !== 8) begin n_fail++; $display("FAIL bp_drain_count: got %0d exp 8", k); end
    endtask

    task automatic test_flush();
        logic [15:0] b0;
        logic        seen = 1'b0;
        for (int j = 1; j <= 8; j++) fq.push_back(8'(8'hA0 + j));
        repeat (4) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        b0 = s_beats;
        n_tests++; if (s_level !== 3'd3) begin n_fail++; $display("FAIL flush_pre_level: got %0d exp 3", s_level); end
        n_tests++; if (s_rd !== 1'b0) begin n_fail++; $display("FAIL flush_rd: got %b exp 0", s_rd); end
        tick(1'b0, 1'b0);
        n_tests++; if (s_level !== 3'd0) begin n_fail++; $display("FAIL flush_level: got %0d exp 0", s_level); end
        n_tests++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b exp 0", s_valid); end
        n_tests++; if (s_beats !== b0) begin n_fail++; $display("FAIL flush_beats: got %0d exp %0d", s_beats, b0); end
        for (int i = 0; i < 20 && (fq.size() != 0 || exp_q.size() != 0); i++) begin
            tick(1'b1, 1'b0);
            if (s_valid && !seen) begin
                seen = 1'b1;
                n_tests++; if (s_data !== 8'hA5) begin n_fail++; $display("FAIL flush_next: got %h exp a5", s_data); end
            end else if (m_valid) begin
                n_tests++; if (s_data !== m_front) begin n_fail++; $display("FAIL flush_drain: got %h exp %h", s_data, m_front); end
            end
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL flush_timeout: got no beat exp a5"); end
    endtask

    task automatic test_random();
        logic       pv = 1'b0, prdy = 1'b0, pfl = 1'b0, rdy, fl;
        logic [7:0] pd = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if (i < 340) begin
                for (int n = $urandom_range(0, 2); n > 0 && fq.size() < 20; n--) fq.push_back(8'($urandom));
                rdy = ($urandom_range(0, 3) != 0);
                fl  = ($urandom_range(0, 24) == 0);
            end else begin
                rdy = 1'b1;
                fl  = 1'b0;
            end
            tick(rdy, fl);
            n_tests++; if (s_rd !== m_rd) begin n_fail++; $display("FAIL rnd_rd c%0d: got %b exp %b", cyc, s_rd, m_rd); end
            n_tests++; if (s_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b exp %b", cyc, s_valid, m_valid); end
            n_tests++; if (s_level !== 3'(m_level)) begin n_fail++; $display("FAIL rnd_level c%0d: got %0d exp %0d", cyc, s_level, m_level); end
            n_tests++; if (s_beats !== 16'(m_beats)) begin n_fail++; $display("FAIL rnd_beats c%0d: got %0d exp %0d", cyc, s_beats, m_beats); end
            if (m_valid) begin
                n_tests++; if (s_data !== m_front) begin n_fail++; $display("FAIL rnd_data c%0d: got %h exp %h", cyc, s_data, m_front); end
            end
            if (pv && !prdy && !pfl) begin
                n_tests++; if (s_valid !== 1'b1 || s_data !== pd) begin n_fail++; $display("FAIL rnd_hold c%0d: got %b/%h exp 1/%h", cyc, s_valid, s_data, pd); end
            end
            pv = s_valid; pd = s_data; prdy = rdy; pfl = fl;
        end
        n_tests++; if (exp_q.size() != 0 || fq.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got %0d/%0d words left exp 0", fq.size(), exp_q.size()); end
    endtask

    task automatic test_midreset();
        for (int j = 0; j < 8; j++) fq.push_back(8'($urandom));
        repeat (3) tick(1'b0, 1'b0);
        a.in_fifo_empty = 1'b0;
        a.in_ready      = 1'b0;
        #1;
        n_tests++; if (a.out_level !== 3'd2) begin n_fail++; $display("FAIL mrst_pre_level: got %0d exp 2", a.out_level); end
        rst = 1'b1;
        #1;
        n_tests++; if (a.out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %b exp 0", a.out_valid); end
        n_tests++; if (a.out_level !== 3'd0) begin n_fail++; $display("FAIL mrst_level: got %0d exp 0", a.out_level); end
        n_tests++; if (a.out_beats !== 16'd0) begin n_fail++; $display("FAIL mrst_beats: got %0d exp 0", a.out_beats); end
        @(negedge clk);
        n_tests++; if (a.out_fifo_rd !== 1'b0) begin n_fail++; $display("FAIL mrst_rd: got %b exp 0", a.out_fifo_rd); end
        rst = 1'b0;
        reset_model();
        a.in_fifo_empty = 1'b1;
    endtask

    task automatic test_wrap_skid2();
        int         acc = 0, pops = 0;
        logic       bprev = 1'b0;
        logic [7:0] bword = 8'h00;
        for (int c = 0; c < 100 && acc < 17; c++) begin
            b.in_fifo_rdata = bprev ? bword : 8'($urandom);
            b.in_fifo_empty = 1'b0;
            b.in_ready      = 1'b1;
            b.in_flush      = 1'b0;
            #1;
            n_tests++; if (b.out_beats !== 4'(acc)) begin n_fail++; $display("FAIL wrap_beats c%0d: got %0d exp %0d", c, b.out_beats, 4'(acc)); end
            n_tests++; if (b.out_level > 2'd2) begin n_fail++; $display("FAIL wrap_level c%0d: got %0d exp <=2", c, b.out_level); end
            if (b.out_valid) begin
                n_tests++; if (b.out_data !== 8'(acc)) begin n_fail++; $display("FAIL wrap_data c%0d: got %h exp %h", c, b.out_data, 8'(acc)); end
                acc++;
            end
            bprev = b.out_fifo_rd;
            if (bprev) begin
                bword = 8'(pops);
                pops++;
            end
            @(negedge clk);
        end
        b.in_ready      = 1'b0;
        b.in_fifo_empty = 1'b1;
        #1;
        n_tests++; if (acc !== 17) begin n_fail++; $display("FAIL wrap_timeout: got %0d beats exp 17", acc); end
        n_tests++; if (b.out_beats !== 4'd1) begin n_fail++; $display("FAIL wrap_final: got %0d exp 1", b.out_beats); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        reset_model();
        test_reset();
        test_basic();
        test_stream();
        test_backpressure();
        test_flush();
        test_random();
        test_midreset();
        test_wrap_skid2();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
